// File: rtl/instr_fetch.sv
// Instruction fetch stage: program counter, IF/ID pipeline register and a RUN/HALT FSM.
// Branch redirect takes priority over stall, stall over halt, and halt over normal fetch.
module instr_fetch #(
  parameter int          PC_W      = 8,
  parameter logic [4:0]  HALT_OP   = 5'b11111,
  parameter logic [16:0] NOP_INSTR = 17'b10101_000_000_000_000
) (
  input  logic            clk,
  input  logic            rst,
  output logic [PC_W-1:0] imem_addr,
  input  logic [16:0]     imem_data,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  output logic [16:0]     instr_line,
  output logic [PC_W-1:0] pc_id,
  output logic            id_valid,
  output logic            halted
);

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pc_id_q, pc_id_d;
  logic [16:0]     instr_q, instr_d;
  logic            vld_q, vld_d;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pc_id_d = pc_id_q;
    instr_d = instr_q;
    vld_d   = vld_q;
    if (branch_taken) begin
      // A resolved branch also cancels a wrong-path HALT; pc_id keeps its last value.
      pc_d    = branch_target;
      instr_d = NOP_INSTR;
      vld_d   = 1'b0;
      state_d = S_RUN;
    end else if (stall) begin
      state_d = state_q;
    end else if (state_q == S_HALT) begin
      instr_d = NOP_INSTR;
      vld_d   = 1'b0;
    end else begin
      instr_d = imem_data;
      pc_id_d = pc_q;
      vld_d   = 1'b1;
      if (imem_data[16:12] == HALT_OP) begin
        state_d = S_HALT;
      end else begin
        pc_d = pc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RUN;
      pc_q    <= '0;
      pc_id_q <= '0;
      instr_q <= NOP_INSTR;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pc_id_q <= pc_id_d;
      instr_q <= instr_d;
      vld_q   <= vld_d;
    end
  end

  assign imem_addr  = pc_q;
  assign instr_line = instr_q;
  assign pc_id      = pc_id_q;
  assign id_valid   = vld_q;
  assign halted     = (state_q == S_HALT);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: sequential fetch, stall, branch, halt, wrap and async reset.
module tb_instr_fetch;

  localparam logic [16:0] NOP = 17'b10101_000_000_000_000;

  logic        clk;
  logic        rst;
  logic [7:0]  imem_addr;
  logic [16:0] imem_data;
  logic        stall;
  logic        branch_taken;
  logic [7:0]  branch_target;
  logic [16:0] instr_line;
  logic [7:0]  pc_id;
  logic        id_valid;
  logic        halted;

  logic [16:0] imem [256];
  int n_vec;
  int n_bad;

  instr_fetch dut (
    .clk           (clk),
    .rst           (rst),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .instr_line    (instr_line),
    .pc_id         (pc_id),
    .id_valid      (id_valid),
    .halted        (halted)
  );

  assign imem_data = imem[imem_addr];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string name, input logic [7:0] e_addr, input logic [16:0] e_instr,
                           input logic [7:0] e_pc_id, input logic e_vld, input logic e_halted);
    n_vec++;
    if (imem_addr !== e_addr || instr_line !== e_instr || pc_id !== e_pc_id ||
        id_valid !== e_vld || halted !== e_halted) begin
      n_bad++;
      $display("FAIL %s: got addr=%h instr=%h pc_id=%h vld=%b halted=%b, want addr=%h instr=%h pc_id=%h vld=%b halted=%b",
               name, imem_addr, instr_line, pc_id, id_valid, halted,
               e_addr, e_instr, e_pc_id, e_vld, e_halted);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #2;
    check_all("reset_state", 8'h00, NOP, 8'h00, 1'b0, 1'b0);
    step();
    check_all("reset_held_over_edge", 8'h00, NOP, 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic test_sequential();
    logic [16:0] exp_w [4];
    exp_w[0] = 17'h00298; exp_w[1] = 17'h01298; exp_w[2] = 17'h02298; exp_w[3] = 17'h03298;
    check_all("seq_before_first_edge", 8'h00, NOP, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      check_all($sformatf("seq_word%0d", i), 8'(i + 1), exp_w[i], 8'(i), 1'b1, 1'b0);
    end
  endtask

  task automatic test_stall();
    do_reset();
    step();
    step();
    check_all("stall_pre", 8'h02, 17'h01298, 8'h01, 1'b1, 1'b0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_all($sformatf("stall_hold%0d", i), 8'h02, 17'h01298, 8'h01, 1'b1, 1'b0);
    end
    stall = 1'b0;
    step();
    check_all("stall_resume", 8'h03, 17'h02298, 8'h02, 1'b1, 1'b0);
    step();
    check_all("stall_no_dup", 8'h04, 17'h03298, 8'h03, 1'b1, 1'b0);
  endtask

  task automatic test_branch_over_stall();
    stall = 1'b1;
    branch_taken = 1'b1;
    branch_target = 8'h40;
    step();
    stall = 1'b0;
    branch_taken = 1'b0;
    branch_target = 8'h00;
    check_all("branch_bubble", 8'h40, NOP, 8'h03, 1'b0, 1'b0);
    step();
    check_all("branch_target_word", 8'h41, 17'h00040, 8'h40, 1'b1, 1'b0);
  endtask

  task automatic test_halt();
    imem[5] = 17'h1F000;
    do_reset();
    for (int i = 0; i < 5; i++) step();
    check_all("halt_pre", 8'h05, 17'h00004, 8'h04, 1'b1, 1'b0);
    step();
    check_all("halt_word", 8'h05, 17'h1F000, 8'h05, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) begin
      step();
      check_all($sformatf("halt_bubble%0d", i), 8'h05, NOP, 8'h05, 1'b0, 1'b1);
    end
    stall = 1'b1;
    step();
    stall = 1'b0;
    check_all("halt_stalled", 8'h05, NOP, 8'h05, 1'b0, 1'b1);
    branch_taken = 1'b1;
    branch_target = 8'h10;
    step();
    branch_taken = 1'b0;
    check_all("halt_exit_branch", 8'h10, NOP, 8'h05, 1'b0, 1'b0);
    step();
    check_all("halt_exit_fetch", 8'h11, 17'h00010, 8'h10, 1'b1, 1'b0);
    imem[5] = 17'h00005;
  endtask

  task automatic test_wrap();
    branch_taken = 1'b1;
    branch_target = 8'hFF;
    step();
    branch_taken = 1'b0;
    check_all("wrap_branch", 8'hFF, NOP, 8'h10, 1'b0, 1'b0);
    step();
    check_all("wrap_last", 8'h00, 17'h000FF, 8'hFF, 1'b1, 1'b0);
    step();
    check_all("wrap_zero", 8'h01, 17'h00298, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_async_reset();
    step();
    check_all("areset_pre", 8'h02, 17'h01298, 8'h01, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    check_all("areset_immediate", 8'h00, NOP, 8'h00, 1'b0, 1'b0);
    #1 rst = 1'b0;
    step();
    check_all("areset_first_fetch", 8'h01, 17'h00298, 8'h00, 1'b1, 1'b0);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst = 1'b0;
    stall = 1'b0;
    branch_taken = 1'b0;
    branch_target = 8'h00;
    for (int i = 0; i < 256; i++) imem[i] = 17'(i);
    imem[0] = 17'h00298;
    imem[1] = 17'h01298;
    imem[2] = 17'h02298;
    imem[3] = 17'h03298;

    test_reset();
    test_sequential();
    test_stall();
    test_branch_over_stall();
    test_halt();
    test_wrap();
    test_async_reset();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
